// File: rtl/dma_reg_bank_if.sv
// Register bus between a host and the DMA register bank.
// Reads are registered: rdata and rd_valid follow rd_en by one cycle.
interface dma_reg_bank_if #(
  parameter int BUS_AW = 12
);
  logic              wr_en;
  logic              rd_en;
  logic [BUS_AW-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rd_valid;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, rd_valid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rd_valid);
endinterface

// File: rtl/dma_reg_bank.sv
// Multi-channel DMA register bank: per-channel SRC/DST/LEN/CTRL/STATUS,
// start pulses to the engine, W1C status and one aggregated interrupt.
module dma_reg_ch #(
  parameter int DMA_AW = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [2:0]        off,
  input  logic [31:0]       wdata,
  input  logic              eng_done,
  input  logic              eng_err,
  output logic              start,
  output logic              ie,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DMA_AW-1:0] src,
  output logic [DMA_AW-1:0] dst,
  output logic [LEN_W-1:0]  len
);
  logic wr_ctrl, wr_src, wr_dst, wr_len, wr_stat;
  logic launch, len_err, done_set, err_set, done_clr, err_clr;
  logic unused_wdata;

  assign wr_ctrl = wr && (off == 3'd0);
  assign wr_src  = wr && (off == 3'd1);
  assign wr_dst  = wr && (off == 3'd2);
  assign wr_len  = wr && (off == 3'd3);
  assign wr_stat = wr && (off == 3'd4);

  assign launch   = wr_ctrl && wdata[0] && !busy && (len != '0);
  assign len_err  = wr_ctrl && wdata[0] && !busy && (len == '0);
  // engine pulses only count while a transfer is outstanding
  assign done_set = busy && eng_done;
  assign err_set  = (busy && eng_err) || len_err;
  assign done_clr = launch || (wr_stat && wdata[1]);
  assign err_clr  = launch || (wr_stat && wdata[2]);
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start <= 1'b0;
      ie    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
    end else begin
      start <= launch;
      if (wr_ctrl) ie <= wdata[1];
      if (launch) busy <= 1'b1;
      else if (busy && (eng_done || eng_err)) busy <= 1'b0;
      // set beats a same-cycle W1C
      if (done_set) done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      if (err_set) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (!busy) begin
        if (wr_src) src <= wdata[DMA_AW-1:0];
        if (wr_dst) dst <= wdata[DMA_AW-1:0];
        if (wr_len) len <= wdata[LEN_W-1:0];
      end
    end
  end
endmodule

module dma_reg_bank #(
  parameter int          NUM_CH  = 4,
  parameter int          BUS_AW  = 12,
  parameter int          DMA_AW  = 32,
  parameter int          LEN_W   = 16,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  dma_reg_bank_if.slave            bus,
  output logic [NUM_CH-1:0]        ch_start,
  output logic [NUM_CH*DMA_AW-1:0] ch_src,
  output logic [NUM_CH*DMA_AW-1:0] ch_dst,
  output logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH-1:0]        ch_err,
  output logic                     irq
);
  logic [NUM_CH-1:0] ie, busy, done, err, int_status;
  logic              hi_zero, glb;
  logic [3:0]        ch_sel;
  logic [2:0]        off;
  logic [31:0]       rd_val;
  logic              unused_addr;

  // anything at or above 0x400 is unmapped
  assign hi_zero     = (bus.addr >> 10) == BUS_AW'(0);
  assign glb         = bus.addr[9];
  assign ch_sel      = bus.addr[8:5];
  assign off         = bus.addr[4:2];
  assign int_status  = ie & (done | err);
  assign unused_addr = ^bus.addr[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dma_reg_ch #(.DMA_AW(DMA_AW), .LEN_W(LEN_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr       (bus.wr_en && hi_zero && !glb && (ch_sel == 4'(c))),
      .off      (off),
      .wdata    (bus.wdata),
      .eng_done (ch_done[c]),
      .eng_err  (ch_err[c]),
      .start    (ch_start[c]),
      .ie       (ie[c]),
      .busy     (busy[c]),
      .done     (done[c]),
      .err      (err[c]),
      .src      (ch_src[c*DMA_AW +: DMA_AW]),
      .dst      (ch_dst[c*DMA_AW +: DMA_AW]),
      .len      (ch_len[c*LEN_W +: LEN_W])
    );
  end

  always_comb begin
    rd_val = '0;
    if (hi_zero) begin
      if (glb) begin
        if (bus.addr[8:2] == 7'd0) rd_val[NUM_CH-1:0] = int_status;
        else if (bus.addr[8:2] == 7'd1) rd_val = VERSION;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel == 4'(c)) begin
            case (off)
              3'd0: rd_val[1] = ie[c];
              3'd1: rd_val[DMA_AW-1:0] = ch_src[c*DMA_AW +: DMA_AW];
              3'd2: rd_val[DMA_AW-1:0] = ch_dst[c*DMA_AW +: DMA_AW];
              3'd3: rd_val[LEN_W-1:0] = ch_len[c*LEN_W +: LEN_W];
              3'd4: rd_val[2:0] = {err[c], done[c], busy[c]};
              default: rd_val = '0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata    <= '0;
      bus.rd_valid <= 1'b0;
      irq          <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rdata <= rd_val;
      irq <= |int_status;
    end
  end
endmodule

// File: tb/tb_dma_reg_bank.sv
// Bench for dma_reg_bank: directed vector table, reset corner case, and
// randomized traffic against a register-level reference model.
module tb_dma_reg_bank;
  localparam int NUM_CH = 4, BUS_AW = 12, DMA_AW = 20, LEN_W = 16;
  localparam logic [31:0] VER = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH-1:0]        ch_start, ch_done, ch_err;
  logic [NUM_CH*DMA_AW-1:0] ch_src, ch_dst;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic                     irq;

  always #5 clk = ~clk;

  dma_reg_bank_if #(.BUS_AW(BUS_AW)) bus ();

  dma_reg_bank #(.NUM_CH(NUM_CH), .BUS_AW(BUS_AW), .DMA_AW(DMA_AW),
                 .LEN_W(LEN_W), .VERSION(VER)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ch_start(ch_start), .ch_src(ch_src),
    .ch_dst(ch_dst), .ch_len(ch_len), .ch_done(ch_done), .ch_err(ch_err),
    .irq(irq));

  // reference model: plain per-channel register arrays
  logic [DMA_AW-1:0] m_src [NUM_CH];
  logic [DMA_AW-1:0] m_dst [NUM_CH];
  logic [LEN_W-1:0]  m_len [NUM_CH];
  logic [NUM_CH-1:0] m_ie, m_busy, m_done, m_err, x_start;
  logic [31:0]       m_rdata;
  logic              x_irq;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic wr; logic rd; logic [11:0] a; logic [31:0] d;
    logic [3:0] dn; logic [3:0] er;
    logic [3:0] x_start; logic [31:0] x_rdata; logic x_irq;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_len[c] = '0;
    end
    m_ie = '0; m_busy = '0; m_done = '0; m_err = '0; m_rdata = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int c = int'(a[8:5]);
    if (a[11:10] != 2'b00) return 32'h0;
    if (a[9]) begin
      if (a[8:2] == 7'd0) return 32'(m_ie & (m_done | m_err));
      if (a[8:2] == 7'd1) return VER;
      return 32'h0;
    end
    if (c >= NUM_CH) return 32'h0;
    case (a[4:2])
      3'd0: return {30'b0, m_ie[c], 1'b0};
      3'd1: return 32'(m_src[c]);
      3'd2: return 32'(m_dst[c]);
      3'd3: return 32'(m_len[c]);
      3'd4: return {29'b0, m_err[c], m_done[c], m_busy[c]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_apply(input logic wr, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] dn, input logic [3:0] er);
    logic [NUM_CH-1:0] b0 = m_busy;
    int c = int'(a[8:5]);
    x_start = '0;
    for (int k = 0; k < NUM_CH; k++) if (b0[k] && (dn[k] || er[k])) m_busy[k] = 1'b0;
    if (wr && a[11:9] == 3'b000 && c < NUM_CH) begin
      case (a[4:2])
        3'd0: begin
          m_ie[c] = d[1];
          if (d[0] && !b0[c]) begin
            if (m_len[c] != '0) begin
              x_start[c] = 1'b1; m_busy[c] = 1'b1; m_done[c] = 1'b0; m_err[c] = 1'b0;
            end else m_err[c] = 1'b1;
          end
        end
        3'd1: if (!b0[c]) m_src[c] = d[DMA_AW-1:0];
        3'd2: if (!b0[c]) m_dst[c] = d[DMA_AW-1:0];
        3'd3: if (!b0[c]) m_len[c] = d[LEN_W-1:0];
        3'd4: begin
          if (d[1]) m_done[c] = 1'b0;
          if (d[2]) m_err[c] = 1'b0;
        end
        default: ;
      endcase
    end
    for (int k = 0; k < NUM_CH; k++) if (b0[k]) begin
      if (dn[k]) m_done[k] = 1'b1;
      if (er[k]) m_err[k] = 1'b1;
    end
  endtask

  // one bus cycle: drive, advance model, compare every output after the edge
  task automatic step(input logic wr, input logic rd, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] dn, input logic [3:0] er);
    logic [NUM_CH*DMA_AW-1:0] xs, xd;
    logic [NUM_CH*LEN_W-1:0]  xl;
    bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.wdata = d;
    ch_done = dn; ch_err = er;
    x_irq = |(m_ie & (m_done | m_err));
    if (rd) m_rdata = m_read(a);
    m_apply(wr, a, d, dn, er);
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; ch_done = '0; ch_err = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      xs[k*DMA_AW +: DMA_AW] = m_src[k];
      xd[k*DMA_AW +: DMA_AW] = m_dst[k];
      xl[k*LEN_W +: LEN_W]   = m_len[k];
    end
    chk("rd_valid", 128'(bus.rd_valid), 128'(rd));
    chk("rdata", 128'(bus.rdata), 128'(m_rdata));
    chk("ch_start", 128'(ch_start), 128'(x_start));
    chk("irq", 128'(irq), 128'(x_irq));
    chk("src_dst_len", {ch_src, ch_dst, ch_len}, {xs, xd, xl});
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    ch_done = '0; ch_err = '0;
    m_reset();

    //         wr    rd    addr     wdata         dn    er    start rdata         irq
    tbl[0]  = '{1'b0, 1'b1, 12'h204, 32'h0,        4'h0, 4'h0, 4'h0, 32'h0002_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 12'h300, 32'h0,        4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, 1'b0, 12'h024, 32'h1000_0000, 4'h0, 4'h0, 4'h0, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 1'b0, 12'h028, 32'h2000_0000, 4'h0, 4'h0, 4'h0, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 12'h02C, 32'h40,       4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[5]  = '{1'b1, 1'b0, 12'h020, 32'h3,        4'h0, 4'h0, 4'h2, 32'h0,         1'b0};
    tbl[6]  = '{1'b0, 1'b1, 12'h030, 32'h0,        4'h0, 4'h0, 4'h0, 32'h1,         1'b0};
    tbl[7]  = '{1'b1, 1'b0, 12'h02C, 32'h80,       4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[8]  = '{1'b1, 1'b0, 12'h020, 32'h3,        4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[9]  = '{1'b0, 1'b1, 12'h02C, 32'h0,        4'h0, 4'h0, 4'h0, 32'h40,        1'b0};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 32'h0,        4'h2, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[11] = '{1'b0, 1'b1, 12'h030, 32'h0,        4'h0, 4'h0, 4'h0, 32'h2,         1'b1};
    tbl[12] = '{1'b0, 1'b1, 12'h200, 32'h0,        4'h0, 4'h0, 4'h0, 32'h2,         1'b1};
    tbl[13] = '{1'b1, 1'b0, 12'h030, 32'h2,        4'h0, 4'h2, 4'h0, 32'h0,         1'b1};
    tbl[14] = '{1'b0, 1'b1, 12'h030, 32'h0,        4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[15] = '{1'b1, 1'b0, 12'h000, 32'h1,        4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[16] = '{1'b0, 1'b1, 12'h010, 32'h0,        4'h0, 4'h0, 4'h0, 32'h4,         1'b0};
    tbl[17] = '{1'b1, 1'b0, 12'h044, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, 32'h0,        1'b0};
    tbl[18] = '{1'b0, 1'b1, 12'h044, 32'h0,        4'h0, 4'h0, 4'h0, 32'h000F_FFFF, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 12'h020, 32'h0,        4'h0, 4'h0, 4'h0, 32'h2,         1'b0};

    #12;
    chk("reset_outs", {bus.rdata, 31'b0, bus.rd_valid, 28'b0, ch_start, 31'b0, irq},
        128'h0);
    chk("reset_src_dst_len", {ch_src, ch_dst, ch_len}, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].dn, tbl[i].er);
      if (tbl[i].rd) chk($sformatf("tbl%0d_rdata", i), 128'(bus.rdata), 128'(tbl[i].x_rdata));
      chk($sformatf("tbl%0d_start", i), 128'(ch_start), 128'(tbl[i].x_start));
      chk($sformatf("tbl%0d_irq", i), 128'(irq), 128'(tbl[i].x_irq));
    end
    chk("ch1_len_out", 128'(ch_len[31:16]), 128'h40);

    // reset in the middle of transfers on channels 0 and 3
    step(1'b1, 1'b0, 12'h00C, 32'h5, 4'h0, 4'h0);
    step(1'b1, 1'b0, 12'h06C, 32'h7, 4'h0, 4'h0);
    step(1'b1, 1'b0, 12'h000, 32'h3, 4'h0, 4'h0);
    chk("rst_seq_start0", 128'(ch_start), 128'h1);
    step(1'b1, 1'b0, 12'h060, 32'h3, 4'h0, 4'h0);
    chk("rst_seq_start3", 128'(ch_start), 128'h8);
    step(1'b0, 1'b0, 12'h000, 32'h0, 4'h1, 4'h0);
    step(1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 4'h0);
    chk("pre_rst_irq", 128'(irq), 128'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_irq", 128'(irq), 128'h0);
    chk("mid_rst_len", 128'(ch_len), 128'h0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 12'h010, 32'h0, 4'h0, 4'h0);
    chk("post_rst_st0", 128'(bus.rdata), 128'h0);
    step(1'b0, 1'b1, 12'h070, 32'h0, 4'h8, 4'h0);
    chk("post_rst_st3", 128'(bus.rdata), 128'h0);
    step(1'b0, 1'b1, 12'h070, 32'h0, 4'h0, 4'h0);
    chk("late_done_st3", 128'(bus.rdata), 128'h0);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        8:       a = 12'h200 + 12'($urandom_range(0, 3) * 4);
        9:       a = 12'($urandom);
        default: a = 12'($urandom_range(0, 4) * 32 + $urandom_range(0, 7) * 4
                      + $urandom_range(0, 3));
      endcase
      d = $urandom;
      if (a[4:2] == 3'd3 && $urandom_range(0, 3) == 0) d = 32'h0;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
           4'($urandom) & 4'($urandom) & 4'($urandom),
           4'($urandom) & 4'($urandom) & 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
